// File: rtl/lane_dmem_port.sv
// lane_dmem_port: per-lane data-memory responder; two request queues round-robin onto one word SRAM.
// Optional feature macro: LANE_DMEM_RANGE_CHECK_EN (flag and suppress addresses >= DEPTH).
module lane_dmem_port #(
    parameter int DEPTH      = 1024,
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ADDR = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            I_Ld_Req,
    input  logic [1:0]            I_St_Req,
    input  logic [WIDTH_ADDR-1:0] I_Address1,
    input  logic [WIDTH_ADDR-1:0] I_Address2,
    input  logic [WIDTH_DATA-1:0] I_St_Data1,
    input  logic [WIDTH_DATA-1:0] I_St_Data2,
    output logic                  O_Ack_Ld1,
    output logic                  O_Ack_Ld2,
    output logic [WIDTH_DATA-1:0] O_Ld_Data1,
    output logic [WIDTH_DATA-1:0] O_Ld_Data2,
    output logic                  O_Stall1,
    output logic                  O_Stall2,
    output logic                  O_Err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                  st;
        logic                  oor;
        logic [AW-1:0]         idx;
        logic [WIDTH_DATA-1:0] data;
    } entry_t;

    entry_t                fifo_q [2][FIFO_DEPTH];
    entry_t                entry_in [2];
    entry_t                head;
    logic [PW-1:0]         wr_ptr_q [2], wr_ptr_d [2], rd_ptr_q [2], rd_ptr_d [2];
    logic [CW-1:0]         cnt_q [2], cnt_d [2];
    logic [WIDTH_DATA-1:0] hold_q [2], hold_d [2];
    logic [WIDTH_ADDR-1:0] req_addr [2];
    logic [WIDTH_DATA-1:0] req_data [2];
    logic [WIDTH_DATA-1:0] mem [DEPTH];
    logic [WIDTH_DATA-1:0] rd_data, ld_data;
    logic [1:0]            push, pop, full, acc, req_oor;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic                  resp_vld_q, resp_vld_d, resp_ch_q, resp_ch_d, resp_zero_q, resp_zero_d;
    logic                  gnt_vld, gnt_ch, mem_we;

    assign req_addr[0] = I_Address1;
    assign req_addr[1] = I_Address2;
    assign req_data[0] = I_St_Data1;
    assign req_data[1] = I_St_Data2;

`ifdef LANE_DMEM_RANGE_CHECK_EN
    assign req_oor[0] = (I_Address1 >> AW) != '0;
    assign req_oor[1] = (I_Address2 >> AW) != '0;
`else
    logic unused_addr_hi;
    assign req_oor        = 2'b00;
    assign unused_addr_hi = ^{I_Address1 >> AW, I_Address2 >> AW};
`endif

    // Arbitration, queue bookkeeping, response pipe and sticky error next-state
    always_comb begin
        gnt_vld     = (cnt_q[0] != '0) || (cnt_q[1] != '0);
        gnt_ch      = (cnt_q[1] != '0) && ((cnt_q[0] == '0) || !last_q);
        head        = fifo_q[gnt_ch][rd_ptr_q[gnt_ch]];
        last_d      = gnt_vld ? gnt_ch : last_q;
        resp_vld_d  = gnt_vld && !head.st;
        resp_ch_d   = gnt_ch;
        resp_zero_d = head.oor;
        mem_we      = gnt_vld && head.st && !head.oor && !reset;
        err_d       = err_q;
        push        = 2'b00;
        pop         = 2'b00;
        full        = 2'b00;
        acc         = 2'b00;
        for (int c = 0; c < 2; c++) begin
            push[c]     = I_Ld_Req[c] | I_St_Req[c];
            pop[c]      = gnt_vld && (gnt_ch == 1'(c));
            full[c]     = cnt_q[c] == CW'(FIFO_DEPTH);
            acc[c]      = push[c] && (!full[c] || pop[c]);
            entry_in[c] = '{st: I_St_Req[c], oor: req_oor[c], idx: req_addr[c][AW-1:0], data: req_data[c]};
            err_d       = err_d | (I_Ld_Req[c] & I_St_Req[c]) | (push[c] & !acc[c]) | (push[c] & req_oor[c]);
            wr_ptr_d[c] = wr_ptr_q[c] + PW'(acc[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
            cnt_d[c]    = cnt_q[c] + CW'(acc[c]) - CW'(pop[c]);
            hold_d[c]   = (resp_vld_q && resp_ch_q == 1'(c)) ? ld_data : hold_q[c];
        end
    end

    // Control state; last_grant resets to channel 2 so channel 1 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                hold_q[c]   <= '0;
            end
            last_q      <= 1'b1;
            err_q       <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_ch_q   <= 1'b0;
            resp_zero_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            err_q       <= err_d;
            resp_vld_q  <= resp_vld_d;
            resp_ch_q   <= resp_ch_d;
            resp_zero_q <= resp_zero_d;
        end
    end

    // Queue storage: payload only, validity is tracked by the counts
    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++)
            if (acc[c]) fifo_q[c][wr_ptr_q[c]] <= entry_in[c];
    end

    // Single-port SRAM: write on store grant, registered read on every grant
    always_ff @(posedge clock) begin
        if (mem_we) mem[head.idx] <= head.data;
        rd_data <= mem[head.idx];
    end

    assign ld_data    = resp_zero_q ? '0 : rd_data;
    assign O_Ack_Ld1  = resp_vld_q && !resp_ch_q;
    assign O_Ack_Ld2  = resp_vld_q && resp_ch_q;
    assign O_Ld_Data1 = O_Ack_Ld1 ? ld_data : hold_q[0];
    assign O_Ld_Data2 = O_Ack_Ld2 ? ld_data : hold_q[1];
    assign O_Stall1   = full[0];
    assign O_Stall2   = full[1];
    assign O_Err      = err_q;
endmodule

// File: tb/tb_lane_dmem_port.sv
// tb_lane_dmem_port: directed stimulus with a per-channel scoreboard of expected load acks.
module tb_lane_dmem_port;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  I_Ld_Req = 2'b00, I_St_Req = 2'b00;
    logic [31:0] I_Address1 = '0, I_Address2 = '0, I_St_Data1 = '0, I_St_Data2 = '0;
    logic        O_Ack_Ld1, O_Ack_Ld2, O_Stall1, O_Stall2, O_Err;
    logic [31:0] O_Ld_Data1, O_Ld_Data2;
    int          checks = 0, failures = 0, cyc = 0;
    logic        seen_stall1 = 1'b0, seen_stall2 = 1'b0;

    typedef struct packed { logic [31:0] d; int t; } exp_t;
    exp_t q1[$], q2[$];
    exp_t e1, e2;

`ifdef LANE_DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    lane_dmem_port dut (
        .clock(clock), .reset(reset), .I_Ld_Req(I_Ld_Req), .I_St_Req(I_St_Req),
        .I_Address1(I_Address1), .I_Address2(I_Address2),
        .I_St_Data1(I_St_Data1), .I_St_Data2(I_St_Data2),
        .O_Ack_Ld1(O_Ack_Ld1), .O_Ack_Ld2(O_Ack_Ld2),
        .O_Ld_Data1(O_Ld_Data1), .O_Ld_Data2(O_Ld_Data2),
        .O_Stall1(O_Stall1), .O_Stall2(O_Stall2), .O_Err(O_Err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops the channel's scoreboard and compares data and (when fixed) cycle
    always @(negedge clock) begin
        if (O_Ack_Ld1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack1_unexpected: got ack with data %h expected no ack", O_Ld_Data1);
            end else begin
                e1 = q1.pop_front();
                check("ack1_data", O_Ld_Data1, e1.d);
                if (e1.t >= 0) check("ack1_cycle", cyc, e1.t);
            end
        end
        if (O_Ack_Ld2) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack2_unexpected: got ack with data %h expected no ack", O_Ld_Data2);
            end else begin
                e2 = q2.pop_front();
                check("ack2_data", O_Ld_Data2, e2.d);
                if (e2.t >= 0) check("ack2_cycle", cyc, e2.t);
            end
        end
    end

    task automatic push1(input logic [31:0] d, input int t);
        exp_t e;
        e.d = d; e.t = t;
        q1.push_back(e);
    endtask

    task automatic push2(input logic [31:0] d, input int t);
        exp_t e;
        e.d = d; e.t = t;
        q2.push_back(e);
    endtask

    task automatic req(input logic [1:0] ld, input logic [1:0] st, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] d1, input logic [31:0] d2);
        I_Ld_Req = ld; I_St_Req = st;
        I_Address1 = a1; I_Address2 = a2; I_St_Data1 = d1; I_St_Data2 = d2;
        @(posedge clock); #1;
        I_Ld_Req = 2'b00; I_St_Req = 2'b00;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (6) @(posedge clock);
        #1;
        check("drain_outstanding", q1.size() + q2.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        I_Ld_Req = 2'b00; I_St_Req = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clock);
        check({tag, "_ack1"}, O_Ack_Ld1, 0);
        check({tag, "_ack2"}, O_Ack_Ld2, 0);
        check({tag, "_data1"}, O_Ld_Data1, 0);
        check({tag, "_data2"}, O_Ld_Data2, 0);
        check({tag, "_stall1"}, O_Stall1, 0);
        check({tag, "_stall2"}, O_Stall2, 0);
        check({tag, "_err"}, O_Err, 0);
    endtask

    // Both channels issue 8 requests back to back, holding off while their queue is full
    task automatic burst(input logic st, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] d1, input logic [31:0] d2);
        int n1 = 0, n2 = 0;
        logic g1, g2;
        for (int i = 0; i < 40 && (n1 < 8 || n2 < 8); i++) begin
            g1 = n1 < 8 && !O_Stall1;
            g2 = n2 < 8 && !O_Stall2;
            seen_stall1 |= O_Stall1;
            seen_stall2 |= O_Stall2;
            I_Address1 = a1 + n1; I_Address2 = a2 + n2;
            I_St_Data1 = d1 + n1; I_St_Data2 = d2 + n2;
            I_Ld_Req = st ? 2'b00 : {g2, g1};
            I_St_Req = st ? {g2, g1} : 2'b00;
            if (!st && g1) push1(d1 + n1, -1);
            if (!st && g2) push2(d2 + n2, -1);
            n1 += int'(g1);
            n2 += int'(g2);
            @(posedge clock); #1;
        end
        I_Ld_Req = 2'b00; I_St_Req = 2'b00;
        check("burst_count1", n1, 8);
        check("burst_count2", n2, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        do_reset();
        check_reset_vals("reset");
        // Preload word 0, 1 (ch1) and 2 (ch2); last grant ends on channel 2
        req(2'b00, 2'b01, 0, 0, 32'hA5A5A5A5, 0);
        req(2'b00, 2'b01, 1, 0, 32'h11, 0);
        req(2'b00, 2'b10, 0, 2, 0, 32'h22);
        wait_drain();
        // Simultaneous loads: channel 1 wins the tie
        t = cyc;
        push1(32'h11, t + 2);
        push2(32'h22, t + 3);
        req(2'b11, 2'b00, 1, 2, 0, 0);
        wait_drain();
        // Store then load same address on channel 1
        t = cyc;
        push1(32'hDEADBEEF, t + 3);
        req(2'b00, 2'b01, 5, 0, 32'hDEADBEEF, 0);
        req(2'b01, 2'b00, 5, 0, 0, 0);
        wait_drain();
        @(negedge clock);
        check("store_load_err", O_Err, 0);
        // Saturating bursts: stores then loads, lane honours stall
        burst(1'b1, 16, 24, 32'h100, 32'h200);
        wait_drain();
        seen_stall1 = 1'b0; seen_stall2 = 1'b0;
        burst(1'b0, 16, 24, 32'h100, 32'h200);
        wait_drain();
        check("burst_stall_seen1", seen_stall1, 1);
        check("burst_stall_seen2", seen_stall2, 1);
        @(negedge clock);
        check("burst_err", O_Err, 0);
        // Address DEPTH: wraps to word 0, or zero data plus error with range check
        t = cyc;
        push1(RC ? 32'h0 : 32'hA5A5A5A5, t + 2);
        req(2'b01, 2'b00, 1024, 0, 0, 0);
        wait_drain();
        @(negedge clock);
        check("oor_err", O_Err, RC);
        do_reset();
        check_reset_vals("reset2");
        // Load and store together on channel 2: store kept, load dropped, error
        req(2'b10, 2'b10, 0, 3, 0, 32'h33);
        wait_drain();
        @(negedge clock);
        check("ldst_err", O_Err, 1);
        t = cyc;
        push2(32'h33, t + 2);
        req(2'b10, 2'b00, 0, 3, 0, 0);
        wait_drain();
        do_reset();
        check_reset_vals("reset3");
        // Channel 1 ignores stall with stores while channel 2 keeps the arbiter busy
        seen_stall1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_stall1 |= O_Stall1;
            I_St_Req = 2'b01;
            I_Address1 = 40 + i; I_St_Data1 = i;
            I_Ld_Req = {!O_Stall2, 1'b0};
            I_Address2 = 1;
            if (!O_Stall2) push2(32'h11, -1);
            @(posedge clock); #1;
        end
        I_Ld_Req = 2'b00; I_St_Req = 2'b00;
        wait_drain();
        check("overflow_stall_seen", seen_stall1, 1);
        @(negedge clock);
        check("overflow_err", O_Err, 1);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("overflow_err_sticky", O_Err, 1);
        // Reset one cycle after two loads are queued: no acks for them
        req(2'b11, 2'b00, 1, 2, 0, 0);
        do_reset();
        check_reset_vals("midop");
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("midop_idle_ack1", O_Ack_Ld1, 0);
        check("midop_idle_ack2", O_Ack_Ld2, 0);
        t = cyc;
        push1(32'h11, t + 2);
        push2(32'h22, t + 3);
        req(2'b11, 2'b00, 1, 2, 0, 0);
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
